// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the dmem_ctrl data memory.
//   funct3_e    : load/store operation, encoded as {we, funct3} so that a load
//                 and a store with the same funct3 remain distinct values.
//   state_e     : request FSM states (IDLE, WAIT, RESP).
//   size_e      : access width (byte, halfword, word).
//   op_info_t   : decoded access (legal, size, sign extension).
//   MAX_LATENCY : largest supported request-to-response latency.
package dmem_pkg;

    localparam int MAX_LATENCY = 8;
    // Wide enough to hold LATENCY-2 for every legal latency.
    localparam int CNT_W = $clog2(MAX_LATENCY);

    typedef enum logic [3:0] {
        LB  = 4'b0_000,
        LH  = 4'b0_001,
        LW  = 4'b0_010,
        LBU = 4'b0_100,
        LHU = 4'b0_101,
        SB  = 4'b1_000,
        SH  = 4'b1_001,
        SW  = 4'b1_010
    } funct3_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } size_e;

    typedef struct packed {
        logic  legal;
        size_e size;
        logic  sign_ext;
    } op_info_t;

    // Any {we, funct3} pair outside the eight named operations is illegal.
    function automatic op_info_t decode_op(input logic we, input logic [2:0] funct3);
        op_info_t info;
        info = '{legal: 1'b1, size: SZ_W, sign_ext: 1'b0};
        case ({we, funct3})
            LB:      begin info.size = SZ_B; info.sign_ext = 1'b1; end
            LH:      begin info.size = SZ_H; info.sign_ext = 1'b1; end
            LW:      info.size = SZ_W;
            LBU:     info.size = SZ_B;
            LHU:     info.size = SZ_H;
            SB:      info.size = SZ_B;
            SH:      info.size = SZ_H;
            SW:      info.size = SZ_W;
            default: info.legal = 1'b0;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// dmem_if: request/response bus between the memory stage and dmem_ctrl.
//   master : drives req_valid/req_we/req_addr/req_funct3/req_wdata,
//            receives req_ready/rsp_valid/rsp_rdata/rsp_fault.
//   slave  : the mirror image, used by dmem_ctrl.
// Parameter ADDR_W is the byte-address width.
interface dmem_if #(
    parameter int ADDR_W = 12
);

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [2:0]        req_funct3;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_fault;

    modport master (
        output req_valid, req_we, req_addr, req_funct3, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_funct3, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault
    );

endinterface

// File: rtl/dmem_array.sv
// dmem_array: DEPTH_WORDS x 32-bit storage with per-byte write enables.
//   clk, rst : clock and asynchronous active-high reset (clears every word)
//   we, be   : write strobe and byte enables (be[i] covers wdata[8*i+7:8*i])
//   idx      : word index
//   wdata    : write data, already replicated onto the enabled lanes
//   rdata    : combinational read of word idx
module dmem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // NOTE: the memory must read as zero after reset, so it is built from
    // resettable flops rather than a RAM macro; a RAM cannot be cleared in
    // one edge and would need a scrub sequence instead.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: handshaked RV32I data memory for the memory stage.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : dmem_if.slave (req_valid/req_ready/req_we/req_addr/req_funct3/
//              req_wdata in, rsp_valid/rsp_rdata/rsp_fault out)
// Parameters: ADDR_W (byte address width), DEPTH_WORDS (32-bit words),
// LATENCY (accept edge to rsp_valid, 1..8).
// A request is latched on acceptance; the response strobes for one cycle in
// RESP. Stores commit on the edge that ends RESP unless the access faults.
// Build option DMEM_MISALIGN_TRAP_EN: misaligned halfword/word accesses fault
// instead of being silently aligned down.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus
);

    localparam int IDX_W = ADDR_W - 2;
    localparam int AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [IDX_W:0]   DEPTH_LIM = (IDX_W+1)'(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_LOAD  = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [2:0]        funct3;
        logic [31:0]       wdata;
    } req_t;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    req_t             req_q;
    logic             accept;

    // ------------------------------------------------------------------
    // FSM and latency counter
    // ------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignment so every flop samples
    // the values from before the edge, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                req_q <= '{we:     bus.req_we,
                           addr:   bus.req_addr,
                           funct3: bus.req_funct3,
                           wdata:  bus.req_wdata};
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a value held (no latches).
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bus.req_ready = 1'b0;
        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (LATENCY <= 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign accept = bus.req_valid && bus.req_ready;

    // ------------------------------------------------------------------
    // Access decode on the latched request
    // ------------------------------------------------------------------
    op_info_t         info;
    logic [IDX_W-1:0] word_idx;
    logic [1:0]       lane;
    logic [1:0]       eff_lane;
    logic             out_of_range;
    logic             misalign;
    logic             fault;

    assign info         = decode_op(req_q.we, req_q.funct3);
    assign word_idx     = req_q.addr[ADDR_W-1:2];
    assign lane         = req_q.addr[1:0];
    assign out_of_range = {1'b0, word_idx} >= DEPTH_LIM;

    // Lanes are aligned down to the access size. With trapping enabled a
    // misaligned access faults anyway, so the aligned lane is only ever used
    // for accesses that were already aligned.
    always_comb begin
        eff_lane = lane;
        case (info.size)
            SZ_H:    eff_lane = {lane[1], 1'b0};
            SZ_W:    eff_lane = 2'b00;
            default: eff_lane = lane;
        endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign = ((info.size == SZ_H) && lane[0]) ||
                      ((info.size == SZ_W) && (lane != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign fault = !info.legal || out_of_range || misalign;

    // ------------------------------------------------------------------
    // Storage: store lane steering and commit
    // ------------------------------------------------------------------
    logic        arr_we;
    logic [3:0]  arr_be;
    logic [31:0] arr_wdata;
    logic [31:0] arr_rdata;

    always_comb begin
        arr_be    = 4'b1111;
        arr_wdata = req_q.wdata;
        case (info.size)
            SZ_B: begin
                arr_be    = 4'b0001 << eff_lane;
                arr_wdata = {4{req_q.wdata[7:0]}};
            end
            SZ_H: begin
                arr_be    = eff_lane[1] ? 4'b1100 : 4'b0011;
                arr_wdata = {2{req_q.wdata[15:0]}};
            end
            default: begin
                arr_be    = 4'b1111;
                arr_wdata = req_q.wdata;
            end
        endcase
    end

    // The write is enabled during RESP so it lands on the edge ending RESP.
    assign arr_we = (state_q == RESP) && req_q.we && !fault;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (AW)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (arr_we),
        .be    (arr_be),
        .idx   (word_idx[AW-1:0]),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    // ------------------------------------------------------------------
    // Load extraction and response
    // ------------------------------------------------------------------
    logic [31:0] shifted;
    logic [31:0] load_data;

    assign shifted = arr_rdata >> {eff_lane, 3'b000};

    always_comb begin
        load_data = arr_rdata;
        case (info.size)
            SZ_B: load_data = info.sign_ext ? {{24{shifted[7]}}, shifted[7:0]}
                                            : {24'h0, shifted[7:0]};
            SZ_H: load_data = info.sign_ext ? {{16{shifted[15]}}, shifted[15:0]}
                                            : {16'h0, shifted[15:0]};
            default: load_data = arr_rdata;
        endcase
    end

    always_comb begin
        bus.rsp_valid = (state_q == RESP);
        bus.rsp_fault = bus.rsp_valid && fault;
        bus.rsp_rdata = (bus.rsp_valid && !fault && !req_q.we) ? load_data : 32'h0;
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed self-checking bench for dmem_ctrl.
// Three DUTs (LATENCY 1, 3, 8) share one stimulus bus; only the selected DUT
// sees req_valid, and its outputs are muxed back for checking. The same
// directed sequence runs once per latency.
module tb_dmem_ctrl;
    import dmem_pkg::*;

    localparam int ADDR_W      = 12;
    localparam int DEPTH_WORDS = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [2:0]        req_funct3;
    logic [31:0]       req_wdata;
    int                sel;
    int                cur_lat;

    logic [2:0]  ready_v, valid_v, fault_v;
    logic [31:0] rdata_v [3];

    logic        obs_ready, obs_valid, obs_fault;
    logic [31:0] obs_rdata;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int LAT = (k == 0) ? 1 : (k == 1) ? 3 : 8;
        dmem_if #(.ADDR_W(ADDR_W)) bus ();
        assign bus.req_valid  = req_valid && (sel == k);
        assign bus.req_we     = req_we;
        assign bus.req_addr   = req_addr;
        assign bus.req_funct3 = req_funct3;
        assign bus.req_wdata  = req_wdata;
        assign ready_v[k]     = bus.req_ready;
        assign valid_v[k]     = bus.rsp_valid;
        assign fault_v[k]     = bus.rsp_fault;
        assign rdata_v[k]     = bus.rsp_rdata;

        dmem_ctrl #(
            .ADDR_W      (ADDR_W),
            .DEPTH_WORDS (DEPTH_WORDS),
            .LATENCY     (LAT)
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    always_comb begin
        obs_ready = ready_v[sel];
        obs_valid = valid_v[sel];
        obs_fault = fault_v[sel];
        obs_rdata = rdata_v[sel];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s (latency %0d): got 0x%08h, expected 0x%08h", tag, cur_lat, got, exp);
        end
    endtask

    // Drive a request and return just after its accept edge, then scramble the
    // inputs so any use of unlatched request fields shows up.
    task automatic issue(input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [2:0] f3, input logic [31:0] wd);
        @(negedge clk);
        for (int i = 0; i < 20 && !obs_ready; i++) @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_funct3 = f3;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = ~we;
        req_addr   = ~addr;
        req_funct3 = 3'd7;
        req_wdata  = ~wd;
    endtask

    task automatic do_op(input string tag, input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [2:0] f3, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_ft);
        int          cyc;
        logic [31:0] rd;
        logic        ft;
        issue(we, addr, f3, wd);
        cyc = 1;
        @(negedge clk);
        while (!obs_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, cyc, cur_lat);
        check({tag, "_valid"}, 32'(obs_valid), 32'd1);
        check({tag, "_busy"}, 32'(obs_ready), 32'd0);
        rd = obs_rdata;
        ft = obs_fault;
        check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_fault"}, 32'(ft), 32'(exp_ft));
        @(negedge clk);
        check({tag, "_strobe_off"}, 32'(obs_valid), 32'd0);
        check({tag, "_rdata_off"}, obs_rdata, 32'h0);
    endtask

    task automatic run_pass();
        int fires;
        // Reset and reset-state checks
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_ready", 32'(obs_ready), 32'd1);
        check("reset_valid", 32'(obs_valid), 32'd0);
        check("reset_rdata", obs_rdata, 32'h0);
        check("reset_fault", 32'(obs_fault), 32'd0);

        // Word store/load and byte merge
        do_op("sw_010",  1'b1, 12'h010, 3'd2, 32'hDEADBEEF, 32'h0, 1'b0);
        do_op("lw_010",  1'b0, 12'h010, 3'd2, 32'h0, 32'hDEADBEEF, 1'b0);
        do_op("sb_012",  1'b1, 12'h012, 3'd0, 32'hABCDEF80, 32'h0, 1'b0);
        do_op("lb_012",  1'b0, 12'h012, 3'd0, 32'h0, 32'hFFFFFF80, 1'b0);
        do_op("lbu_012", 1'b0, 12'h012, 3'd4, 32'h0, 32'h00000080, 1'b0);
        do_op("lw_merge",1'b0, 12'h010, 3'd2, 32'h0, 32'hDE80BEEF, 1'b0);

        // Halfword store/load in the upper lane
        do_op("sh_016",  1'b1, 12'h016, 3'd1, 32'h12348001, 32'h0, 1'b0);
        do_op("lh_016",  1'b0, 12'h016, 3'd1, 32'h0, 32'hFFFF8001, 1'b0);
        do_op("lhu_016", 1'b0, 12'h016, 3'd5, 32'h0, 32'h00008001, 1'b0);
        do_op("lw_014",  1'b0, 12'h014, 3'd2, 32'h0, 32'h80010000, 1'b0);

        // Misaligned accesses
`ifdef DMEM_MISALIGN_TRAP_EN
        do_op("lw_mis",  1'b0, 12'h011, 3'd2, 32'h0, 32'h0, 1'b1);
        do_op("lh_mis",  1'b0, 12'h017, 3'd1, 32'h0, 32'h0, 1'b1);
`else
        do_op("lw_mis",  1'b0, 12'h011, 3'd2, 32'h0, 32'hDE80BEEF, 1'b0);
        do_op("lh_mis",  1'b0, 12'h017, 3'd1, 32'h0, 32'hFFFF8001, 1'b0);
`endif

        // Faults, each followed by a readback showing memory untouched
        do_op("sw_oor",  1'b1, 12'h400, 3'd2, 32'h11111111, 32'h0, 1'b1);
        do_op("lw_alias",1'b0, 12'h000, 3'd2, 32'h0, 32'h0, 1'b0);
        do_op("lb_oor",  1'b0, 12'h7FC, 3'd0, 32'h0, 32'h0, 1'b1);
        do_op("ld_f3_3", 1'b0, 12'h010, 3'd3, 32'h0, 32'h0, 1'b1);
        do_op("ld_f3_6", 1'b0, 12'h010, 3'd6, 32'h0, 32'h0, 1'b1);
        do_op("st_f3_4", 1'b1, 12'h010, 3'd4, 32'h55555555, 32'h0, 1'b1);
        do_op("lw_after",1'b0, 12'h010, 3'd2, 32'h0, 32'hDE80BEEF, 1'b0);

        // Reset while a store is in flight
        issue(1'b1, 12'h020, 3'd2, 32'h12345678);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        fires = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (obs_valid) fires++;
        end
        check("rst_no_rsp", fires, 0);
        check("rst_ready", 32'(obs_ready), 32'd1);
        do_op("rst_lw_020", 1'b0, 12'h020, 3'd2, 32'h0, 32'h0, 1'b0);
        do_op("rst_lw_010", 1'b0, 12'h010, 3'd2, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_funct3 = 3'd0;
        req_wdata  = 32'h0;
        sel        = 0;
        cur_lat    = 1;
        for (int p = 0; p < 3; p++) begin
            sel     = p;
            cur_lat = (p == 0) ? 1 : (p == 1) ? 3 : 8;
            run_pass();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish, %0d vectors applied", n_vec);
        $fatal(1, "watchdog expired");
    end

endmodule
